truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
Response-side companion to the exhaustive 3-input stimulus driver. It watches the driven vector {a,b,c} and the DUT output y, waits a fixed settle interval after each vector change, and samples y once. Each sample is graded against a parameterised 8-entry truth table. The block accumulates pass/fail counts and vector coverage, and raises done/pass once all 8 vectors have been graded. It sits beside the DUT in simulation benches and in on-chip self-test wrappers.

Parameters:
EXPECTED, 8'b1110_1000, expected y per vector; bit index = {a,b,c} (default is 3-input majority)
SETTLE_CYCLES, 4, clk cycles a vector must be stable before y is sampled; legal range 1..255
CNT_W, 4, width of pass/fail counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins (or restarts) a checking run
a  input  1  stimulus bit 2 (MSB of vector index)
b  input  1  stimulus bit 1
c  input  1  stimulus bit 0
y  input  1  DUT response under test
sample_strobe  output  1  one-cycle pulse when y is graded
sample_ok  output  1  grade of the current sample; valid only with sample_strobe
pass_count  output  CNT_W  number of matching samples
fail_count  output  CNT_W  number of mismatching samples
coverage  output  8  bit i set once vector i has been graded
done  output  1  high in DONE state
pass  output  1  high in DONE when fail_count==0

Behaviour:
- Reset values: all outputs 0; state IDLE; settle counter 0; internal vec_q 0.
- Reset has priority over every other input, including mid-settle and in DONE. It clears all counts and coverage.
- Every cycle, vec_q <= {a,b,c}. A vector change means {a,b,c} != vec_q.
- IDLE: outputs held. On start -> SETTLE: load counter with SETTLE_CYCLES; clear counts, coverage and pass.
- SETTLE: decrement the counter each cycle. On a vector change, reload SETTLE_CYCLES (restart). When the counter reaches 1 with no change that cycle -> SAMPLE. Latency from the last vector change to sample_strobe is SETTLE_CYCLES+1 cycles.
- SAMPLE (1 cycle):
  - sample_strobe=1; sample_ok = (y == EXPECTED[{a,b,c}]).
  - Increment pass_count or fail_count; both saturate at 2^CNT_W-1.
  - Set coverage[{a,b,c}].
  - Next state: DONE if coverage (including this bit) is 8'hFF, else HOLD.
- HOLD: wait without re-sampling while the vector is unchanged. On a vector change -> SETTLE with a reload.
- Re-graded vectors: a repeated vector (change away and back) is graded again and counted again; its coverage bit stays set.
- DONE: done=1; pass = (fail_count==0). Vector changes are ignored. On start -> clear and enter SETTLE as from IDLE.
- start in SETTLE or HOLD: restart the run (clear counts/coverage, reload counter).
- Simultaneous start and vector change: start wins; the counter is loaded once.

Optional Feature:
Macro TT_CHECKER_FIRST_FAIL_CAPTURE_EN.
- Defined: adds outputs first_fail_valid (1), first_fail_vec (3) and first_fail_y (1). On the first mismatch of a run these latch the vector and the observed y, and hold until rst or start.
- Not defined: the ports and their registers are absent; behaviour is otherwise identical.

Decomposition:
- Package tt_checker_pkg: state enum (IDLE, SETTLE, SAMPLE, HOLD, DONE), TT_VEC_W=3, TT_NUM_VEC=8, SETTLE_CNT_W=8.
- One natural sub-module: settle_timer, an 8-bit loadable down-counter with load/restart and an expired output. It is instantiated once.

Test Plan:
- Driver steps vectors 0..7, each held 10 cycles, y = majority -> 8 strobes, pass_count=8, fail_count=0, coverage=8'hFF, done=1, pass=1.
- Same sweep with y forced 0 -> fail_count=4 (vectors 3,5,6,7), pass_count=4, pass=0; with the macro defined, first_fail_vec=3 and first_fail_y=0.
- Vector toggled every 2 cycles with SETTLE_CYCLES=4 -> no sample_strobe. Once held, the strobe arrives exactly 5 cycles after the last change.
- Sequence 0,1,0,2..7 -> 9 strobes, pass_count=9, coverage=8'hFF, done asserted after the vector-7 sample.
- rst asserted mid-SETTLE after 3 graded vectors -> next cycle all outputs 0, state IDLE. No strobe occurs until start.
- With SETTLE_CYCLES held at the default 4, force 20 mismatches on alternating vectors (CNT_W=4) -> fail_count saturates at 15 and does not wrap.

Source files
------------

// File: rtl/truth_table_checker_pkg.sv
// Shared types and constants for the truth-table response checker.
// The optional first-fail capture outputs of truth_table_checker are
// enabled by defining TT_CHECKER_FIRST_FAIL_CAPTURE_EN.
package tt_checker_pkg;

   localparam int TT_VEC_W     = 3;
   localparam int TT_NUM_VEC   = 8;
   localparam int SETTLE_CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      SAMPLE = 3'd2,
      HOLD   = 3'd3,
      DONE   = 3'd4
   } tt_state_e;

   // One-hot coverage mask for a stimulus vector.
   function automatic logic [TT_NUM_VEC-1:0] vec_onehot(input logic [TT_VEC_W-1:0] vec);
      logic [TT_NUM_VEC-1:0] one;
      one        = {{(TT_NUM_VEC-1){1'b0}}, 1'b1};
      vec_onehot = one << vec;
   endfunction

   // Settle reload value, clamped into the counter's legal 1..255 range.
   function automatic logic [SETTLE_CNT_W-1:0] settle_load(input int cycles);
      logic [SETTLE_CNT_W-1:0] val;
      if (cycles < 1) begin
         val = {{(SETTLE_CNT_W-1){1'b0}}, 1'b1};
      end else if (cycles > 255) begin
         val = {SETTLE_CNT_W{1'b1}};
      end else begin
         val = SETTLE_CNT_W'(cycles);
      end
      settle_load = val;
   endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Loadable down-counter that flags when the settle interval is about to
// elapse (count of 1). Load has priority over decrement; the counter
// parks at zero rather than wrapping.
module settle_timer
   import tt_checker_pkg::*;
#(
   parameter int W = SETTLE_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic         expired_q;
   logic         expired_d;

   // Next count: reload, decrement toward zero, or hold.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != {W{1'b0}})) begin
         count_d = count_q - W'(1);
      end else begin
         count_d = count_q;
      end
      expired_d = (count_d == W'(1));
   end

   // Counter and registered expiry flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= {W{1'b0}};
         expired_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         expired_q <= expired_d;
      end
   end

   assign expired = expired_q;

endmodule

// File: rtl/truth_table_checker.sv
// Truth-table response checker: waits for {a,b,c} to settle, grades y
// against EXPECTED, accumulates pass/fail counts and vector coverage.
// Optional macro TT_CHECKER_FIRST_FAIL_CAPTURE_EN adds first-mismatch
// capture outputs (first_fail_valid/vec/y).
module truth_table_checker
   import tt_checker_pkg::*;
#(
   parameter logic [TT_NUM_VEC-1:0] EXPECTED      = 8'b1110_1000,
   parameter int                    SETTLE_CYCLES = 4,
   parameter int                    CNT_W         = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  a,
   input  logic                  b,
   input  logic                  c,
   input  logic                  y,
   output logic                  sample_strobe,
   output logic                  sample_ok,
   output logic [CNT_W-1:0]      pass_count,
   output logic [CNT_W-1:0]      fail_count,
   output logic [TT_NUM_VEC-1:0] coverage,
`ifdef TT_CHECKER_FIRST_FAIL_CAPTURE_EN
   output logic                  first_fail_valid,
   output logic [TT_VEC_W-1:0]   first_fail_vec,
   output logic                  first_fail_y,
`endif
   output logic                  done,
   output logic                  pass
);

   localparam logic [SETTLE_CNT_W-1:0] LOAD_VAL = settle_load(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0]        CNT_MAX  = {CNT_W{1'b1}};

   tt_state_e             state_q, state_d;
   logic [TT_VEC_W-1:0]   vec_q, vec_d;
   logic                  strobe_q, strobe_d;
   logic                  ok_q, ok_d;
   logic [CNT_W-1:0]      pass_count_q, pass_count_d;
   logic [CNT_W-1:0]      fail_count_q, fail_count_d;
   logic [TT_NUM_VEC-1:0] coverage_q, coverage_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
`ifdef TT_CHECKER_FIRST_FAIL_CAPTURE_EN
   logic                  ff_valid_q, ff_valid_d;
   logic [TT_VEC_W-1:0]   ff_vec_q, ff_vec_d;
   logic                  ff_y_q, ff_y_d;
`endif

   logic [TT_VEC_W-1:0]   cur_vec_s;
   logic                  vec_change_s;
   logic                  grade_ok_s;
   logic                  timer_load_s;
   logic                  timer_dec_s;
   logic                  timer_expired_s;

   assign cur_vec_s    = {a, b, c};
   assign vec_change_s = (cur_vec_s != vec_q);
   assign grade_ok_s   = (y == EXPECTED[cur_vec_s]);

   settle_timer #(
      .W (SETTLE_CNT_W)
   ) u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load_s),
      .dec      (timer_dec_s),
      .load_val (LOAD_VAL),
      .expired  (timer_expired_s)
   );

   // Next-state, grading and bookkeeping; start overrides every state.
   always_comb begin
      state_d      = state_q;
      vec_d        = cur_vec_s;
      strobe_d     = 1'b0;
      ok_d         = 1'b0;
      pass_count_d = pass_count_q;
      fail_count_d = fail_count_q;
      coverage_d   = coverage_q;
      done_d       = done_q;
      pass_d       = pass_q;
      timer_load_s = 1'b0;
      timer_dec_s  = 1'b0;
`ifdef TT_CHECKER_FIRST_FAIL_CAPTURE_EN
      ff_valid_d   = ff_valid_q;
      ff_vec_d     = ff_vec_q;
      ff_y_d       = ff_y_q;
`endif

      if (start) begin
         state_d      = SETTLE;
         timer_load_s = 1'b1;
         pass_count_d = {CNT_W{1'b0}};
         fail_count_d = {CNT_W{1'b0}};
         coverage_d   = {TT_NUM_VEC{1'b0}};
         done_d       = 1'b0;
         pass_d       = 1'b0;
`ifdef TT_CHECKER_FIRST_FAIL_CAPTURE_EN
         ff_valid_d   = 1'b0;
         ff_vec_d     = {TT_VEC_W{1'b0}};
         ff_y_d       = 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            SETTLE: begin
               if (vec_change_s) begin
                  timer_load_s = 1'b1;
               end else if (timer_expired_s) begin
                  // Vector has been stable long enough: grade it now so the
                  // strobe and updated counts appear together in SAMPLE.
                  state_d    = SAMPLE;
                  strobe_d   = 1'b1;
                  ok_d       = grade_ok_s;
                  coverage_d = coverage_q | vec_onehot(cur_vec_s);
                  if (grade_ok_s) begin
                     if (pass_count_q != CNT_MAX) begin
                        pass_count_d = pass_count_q + CNT_W'(1);
                     end else begin
                        pass_count_d = pass_count_q;
                     end
                  end else begin
                     if (fail_count_q != CNT_MAX) begin
                        fail_count_d = fail_count_q + CNT_W'(1);
                     end else begin
                        fail_count_d = fail_count_q;
                     end
                  end
`ifdef TT_CHECKER_FIRST_FAIL_CAPTURE_EN
                  if (!grade_ok_s && !ff_valid_q) begin
                     ff_valid_d = 1'b1;
                     ff_vec_d   = cur_vec_s;
                     ff_y_d     = y;
                  end else begin
                     ff_valid_d = ff_valid_q;
                  end
`endif
               end else begin
                  timer_dec_s = 1'b1;
               end
            end
            SAMPLE: begin
               if (coverage_q == {TT_NUM_VEC{1'b1}}) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  pass_d  = (fail_count_q == {CNT_W{1'b0}});
               end else if (vec_change_s) begin
                  // A change landing in the sample cycle would be invisible
                  // from HOLD, so start settling on it straight away.
                  state_d      = SETTLE;
                  timer_load_s = 1'b1;
               end else begin
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (vec_change_s) begin
                  state_d      = SETTLE;
                  timer_load_s = 1'b1;
               end else begin
                  state_d = HOLD;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         vec_q        <= {TT_VEC_W{1'b0}};
         strobe_q     <= 1'b0;
         ok_q         <= 1'b0;
         pass_count_q <= {CNT_W{1'b0}};
         fail_count_q <= {CNT_W{1'b0}};
         coverage_q   <= {TT_NUM_VEC{1'b0}};
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
`ifdef TT_CHECKER_FIRST_FAIL_CAPTURE_EN
         ff_valid_q   <= 1'b0;
         ff_vec_q     <= {TT_VEC_W{1'b0}};
         ff_y_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         strobe_q     <= strobe_d;
         ok_q         <= ok_d;
         pass_count_q <= pass_count_d;
         fail_count_q <= fail_count_d;
         coverage_q   <= coverage_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
`ifdef TT_CHECKER_FIRST_FAIL_CAPTURE_EN
         ff_valid_q   <= ff_valid_d;
         ff_vec_q     <= ff_vec_d;
         ff_y_q       <= ff_y_d;
`endif
      end
   end

   assign sample_strobe = strobe_q;
   assign sample_ok     = ok_q;
   assign pass_count    = pass_count_q;
   assign fail_count    = fail_count_q;
   assign coverage      = coverage_q;
   assign done          = done_q;
   assign pass          = pass_q;
`ifdef TT_CHECKER_FIRST_FAIL_CAPTURE_EN
   assign first_fail_valid = ff_valid_q;
   assign first_fail_vec   = ff_vec_q;
   assign first_fail_y     = ff_y_q;
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomised and directed bench for truth_table_checker with a
// behavioural reference model (settle age per vector, majority table).
module tb_truth_table_checker;

   localparam int S  = 4;
   localparam int CW = 4;
   localparam int CMAX = 15;

   logic clk = 1'b0;
   logic rst, start, a, b, c, y;
   logic          sample_strobe, sample_ok, done, pass;
   logic [CW-1:0] pass_count, fail_count;
   logic [7:0]    coverage;
`ifdef TT_CHECKER_FIRST_FAIL_CAPTURE_EN
   logic       first_fail_valid, first_fail_y;
   logic [2:0] first_fail_vec;
`endif

   truth_table_checker #(
      .EXPECTED      (8'b1110_1000),
      .SETTLE_CYCLES (S),
      .CNT_W         (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .a             (a),
      .b             (b),
      .c             (c),
      .y             (y),
      .sample_strobe (sample_strobe),
      .sample_ok     (sample_ok),
      .pass_count    (pass_count),
      .fail_count    (fail_count),
      .coverage      (coverage),
`ifdef TT_CHECKER_FIRST_FAIL_CAPTURE_EN
      .first_fail_valid (first_fail_valid),
      .first_fail_vec   (first_fail_vec),
      .first_fail_y     (first_fail_y),
`endif
      .done          (done),
      .pass          (pass)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int strobes_seen = 0;

   // Reference model state
   logic [2:0] m_prev;
   bit         m_run, m_fin, m_armed, m_done_out, m_graded;
   int         m_age, m_pass_cnt, m_fail_cnt;
   logic [7:0] m_cov;
   bit         m_exp_strobe, m_exp_ok;
   bit         m_ff_valid, m_ff_y;
   logic [2:0] m_ff_vec;

   function automatic bit majority(input logic [2:0] v);
      return (int'(v[2]) + int'(v[1]) + int'(v[0])) >= 2;
   endfunction

   task automatic model_clear();
      m_fin = 0; m_armed = 0; m_done_out = 0; m_graded = 0; m_age = 0;
      m_pass_cnt = 0; m_fail_cnt = 0; m_cov = 8'h00;
      m_ff_valid = 0; m_ff_vec = 3'd0; m_ff_y = 0;
   endtask

   // One clock cycle of stimulus; model predicts what becomes visible after the edge.
   task automatic drive(input bit st, input logic [2:0] v, input bit yy);
      start = st; {a, b, c} = v; y = yy;
      m_exp_strobe = 0; m_exp_ok = 0;
      if (m_armed) begin m_done_out = 1; m_armed = 0; end
      if (st) begin
         model_clear();
         m_run = 1;
      end else if (m_run && !m_fin) begin
         if (v != m_prev) begin
            m_age = 0; m_graded = 0;
         end else begin
            if (m_age < 1000) m_age++;
            if (!m_graded && m_age == S) begin
               m_graded = 1; m_exp_strobe = 1;
               m_exp_ok = (yy == majority(v));
               if (m_exp_ok) m_pass_cnt = (m_pass_cnt < CMAX) ? m_pass_cnt + 1 : CMAX;
               else          m_fail_cnt = (m_fail_cnt < CMAX) ? m_fail_cnt + 1 : CMAX;
               if (!m_exp_ok && !m_ff_valid) begin
                  m_ff_valid = 1; m_ff_vec = v; m_ff_y = yy;
               end
               m_cov[v] = 1'b1;
               if (m_cov == 8'hFF) begin m_fin = 1; m_armed = 1; end
            end
         end
      end
      m_prev = v;
      @(posedge clk); #1;
      n_checks++;
      if (sample_strobe !== m_exp_strobe)
         $display("FAIL strobe: got %b want %b at %0t", sample_strobe, m_exp_strobe, $time);
      else n_pass++;
      if (sample_strobe === 1'b1) strobes_seen++;
      if (m_exp_strobe) begin
         n_checks++;
         if (sample_ok !== m_exp_ok || pass_count !== CW'(m_pass_cnt) || fail_count !== CW'(m_fail_cnt))
            $display("FAIL grade: ok/pass/fail got %b/%0d/%0d want %b/%0d/%0d at %0t",
                     sample_ok, pass_count, fail_count, m_exp_ok, m_pass_cnt, m_fail_cnt, $time);
         else n_pass++;
      end
      n_checks++;
      if (done !== m_done_out || pass !== (m_done_out && m_fail_cnt == 0))
         $display("FAIL done_pass: got %b/%b want %b/%b at %0t", done, pass,
                  m_done_out, (m_done_out && m_fail_cnt == 0), $time);
      else n_pass++;
   endtask

   task automatic do_reset();
      rst = 1; start = 0; {a, b, c} = 3'd5; y = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      model_clear(); m_run = 0; m_prev = 3'd0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({sample_strobe, sample_ok, done, pass} !== 4'b0000 || pass_count !== 4'd0 ||
          fail_count !== 4'd0 || coverage !== 8'h00)
         $display("FAIL reset_state: strobe/ok/done/pass=%b%b%b%b pc=%0d fc=%0d cov=%h want all 0",
                  sample_strobe, sample_ok, done, pass, pass_count, fail_count, coverage);
      else n_pass++;
   endtask

   task automatic test_sweep(input bit force0);
      strobes_seen = 0;
      drive(1'b1, 3'd0, 1'b0);
      for (int v = 0; v < 8; v++)
         for (int k = 0; k < 10; k++)
            drive(1'b0, 3'(v), force0 ? 1'b0 : majority(3'(v)));
      n_checks++;
      if (strobes_seen != 8 || pass_count !== (force0 ? 4'd4 : 4'd8) ||
          fail_count !== (force0 ? 4'd4 : 4'd0) || coverage !== 8'hFF ||
          done !== 1'b1 || pass !== !force0)
         $display("FAIL sweep%0d: strobes=%0d pc=%0d fc=%0d cov=%h done=%b pass=%b",
                  force0, strobes_seen, pass_count, fail_count, coverage, done, pass);
      else n_pass++;
`ifdef TT_CHECKER_FIRST_FAIL_CAPTURE_EN
      n_checks++;
      if (first_fail_valid !== force0 || (force0 && (first_fail_vec !== 3'd3 || first_fail_y !== 1'b0)))
         $display("FAIL first_fail: valid=%b vec=%0d y=%b want valid=%b vec=3 y=0",
                  first_fail_valid, first_fail_vec, first_fail_y, force0);
      else n_pass++;
`endif
   endtask

   task automatic test_toggle();
      int lat;
      strobes_seen = 0;
      drive(1'b1, 3'd1, 1'b0);
      for (int k = 0; k < 20; k++) drive(1'b0, (k / 2) % 2 ? 3'd2 : 3'd1, 1'b0);
      n_checks++;
      if (strobes_seen != 0) $display("FAIL toggle_nostrobe: got %0d strobes want 0", strobes_seen);
      else n_pass++;
      // last toggle value was 3'd2; change to 3'd4 and hold
      lat = 0;
      for (int k = 1; k <= 12 && lat == 0; k++) begin
         drive(1'b0, 3'd4, 1'b0);
         if (sample_strobe === 1'b1) lat = k;
      end
      n_checks++;
      if (lat != S + 1) $display("FAIL settle_latency: got %0d cycles want %0d", lat, S + 1);
      else n_pass++;
   endtask

   task automatic test_repeat();
      int seq[9] = '{0, 1, 0, 2, 3, 4, 5, 6, 7};
      strobes_seen = 0;
      drive(1'b1, 3'd0, 1'b0);
      foreach (seq[i])
         for (int k = 0; k < 10; k++) drive(1'b0, 3'(seq[i]), majority(3'(seq[i])));
      n_checks++;
      if (strobes_seen != 9 || pass_count !== 4'd9 || fail_count !== 4'd0 ||
          coverage !== 8'hFF || done !== 1'b1 || pass !== 1'b1)
         $display("FAIL repeat: strobes=%0d pc=%0d fc=%0d cov=%h done=%b pass=%b",
                  strobes_seen, pass_count, fail_count, coverage, done, pass);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 3'd0, 1'b0);
      for (int v = 0; v < 3; v++)
         for (int k = 0; k < 10; k++) drive(1'b0, 3'(v), majority(3'(v)));
      drive(1'b0, 3'd3, 1'b1);
      drive(1'b0, 3'd3, 1'b1);
      do_reset();
      n_checks++;
      if ({sample_strobe, sample_ok, done, pass} !== 4'b0000 || pass_count !== 4'd0 ||
          fail_count !== 4'd0 || coverage !== 8'h00)
         $display("FAIL reset_mid: pc=%0d fc=%0d cov=%h done=%b want all 0",
                  pass_count, fail_count, coverage, done);
      else n_pass++;
      strobes_seen = 0;
      for (int k = 0; k < 30; k++) drive(1'b0, 3'((k / 7) % 8), 1'b1);
      n_checks++;
      if (strobes_seen != 0) $display("FAIL reset_idle: got %0d strobes want 0", strobes_seen);
      else n_pass++;
   endtask

   task automatic test_saturate();
      drive(1'b1, 3'd4, 1'b0);
      for (int i = 0; i < 20; i++)
         for (int k = 0; k < 6; k++)
            drive(1'b0, (i % 2) ? 3'd4 : 3'd3, !majority((i % 2) ? 3'd4 : 3'd3));
      n_checks++;
      if (fail_count !== 4'd15 || pass_count !== 4'd0 || done !== 1'b0)
         $display("FAIL saturate: fc=%0d pc=%0d done=%b want 15/0/0", fail_count, pass_count, done);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [2:0] v;
      bit yy;
      for (int run = 0; run < 4; run++) begin
         drive(1'b1, 3'($urandom_range(0, 7)), 1'b0);
         for (int seg = 0; seg < 40; seg++) begin
            v = 3'($urandom_range(0, 7));
            yy = ($urandom_range(0, 4) == 0) ? !majority(v) : majority(v);
            for (int k = $urandom_range(1, 8); k > 0; k--)
               drive(($urandom_range(0, 150) == 0), v, yy);
         end
         n_checks++;
         if (pass_count !== CW'(m_pass_cnt) || fail_count !== CW'(m_fail_cnt) || coverage !== m_cov)
            $display("FAIL random_run%0d: pc=%0d fc=%0d cov=%h want %0d/%0d/%h",
                     run, pass_count, fail_count, coverage, m_pass_cnt, m_fail_cnt, m_cov);
         else n_pass++;
`ifdef TT_CHECKER_FIRST_FAIL_CAPTURE_EN
         n_checks++;
         if (first_fail_valid !== m_ff_valid || (m_ff_valid && (first_fail_vec !== m_ff_vec || first_fail_y !== m_ff_y)))
            $display("FAIL random_ff%0d: %b/%0d/%b want %b/%0d/%b", run, first_fail_valid,
                     first_fail_vec, first_fail_y, m_ff_valid, m_ff_vec, m_ff_y);
         else n_pass++;
`endif
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; y = 1'b0;
      m_run = 0; m_prev = 3'd0;
      test_reset();
      test_sweep(1'b0);
      test_sweep(1'b1);
      test_toggle();
      test_repeat();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
